// File: rtl/line_card_egress_tagger_pkg.sv
// Shared Ethernet definitions for the egress tagger: 802.1Q constants, FSM state
// encoding and a saturating counter helper.
package line_card_egress_tagger_pkg;

  localparam logic [15:0]  ETHERTYPE_DOT1Q = 16'h8100;
  localparam int unsigned  VLAN_ID_WIDTH   = 12;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    TAG,
    BODY,
    DROP
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_register_slice.sv
// Single-stage AXI-Stream register slice: accepts a beat when empty or draining,
// holds payload stable while the downstream stalls.
module axis_register_slice #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  input  logic                  s_last,
  input  logic [USER_W-1:0]     s_user,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic [DATA_W/8-1:0]   m_keep,
  output logic                  m_last,
  output logic [USER_W-1:0]     m_user
);

  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W/8-1:0] keep_q, keep_d;
  logic                last_q, last_d;
  logic [USER_W-1:0]   user_q, user_d;

  assign s_ready = !valid_q || m_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    user_d  = user_q;
    if (s_ready) begin
      valid_d = s_valid;
      if (s_valid) begin
        data_d = s_data;
        keep_d = s_keep;
        last_d = s_last;
        user_d = s_user;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_last  = last_q;
  assign m_user  = user_q;

endmodule

// File: rtl/line_card_egress_tagger.sv
// Egress VLAN handling for one port: forwards native-VLAN frames untouched, inserts an
// 802.1Q tag after the MAC addresses on trunk ports, drops everything else.
import line_card_egress_tagger_pkg::*;

module line_card_egress_tagger (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     axi_rx_tvalid,
  output logic                     axi_rx_tready,
  input  logic [31:0]              axi_rx_tdata,
  input  logic [3:0]               axi_rx_tkeep,
  input  logic                     axi_rx_tlast,
  input  logic                     axi_rx_tuser,
  input  logic [VLAN_ID_WIDTH-1:0] rx_vlan,
  output logic                     axi_tx_tvalid,
  input  logic                     axi_tx_tready,
  output logic [31:0]              axi_tx_tdata,
  output logic [3:0]               axi_tx_tkeep,
  output logic                     axi_tx_tlast,
  output logic                     axi_tx_tuser,
  input  logic [VLAN_ID_WIDTH-1:0] port_vlan,
  input  logic                     port_trunk,
  output logic [31:0]              cnt_tagged,
  output logic [31:0]              cnt_untagged,
  output logic [31:0]              cnt_dropped
);

  state_e                   state_q, state_d;
  logic [1:0]               word_cnt_q, word_cnt_d;
  logic                     tagged_q, tagged_d;
  logic [VLAN_ID_WIDTH-1:0] vlan_q, vlan_d;
  logic                     live_q;
  logic [31:0]              cnt_tag_q, cnt_tag_d;
  logic [31:0]              cnt_untag_q, cnt_untag_d;
  logic [31:0]              cnt_drop_q, cnt_drop_d;

  logic        sl_valid, sl_ready;
  logic [31:0] sl_data;
  logic [3:0]  sl_keep;
  logic        sl_last, sl_user;
  logic        rx_fire, first_tagged, first_drop;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    tagged_d    = tagged_q;
    vlan_d      = vlan_q;
    cnt_tag_d   = cnt_tag_q;
    cnt_untag_d = cnt_untag_q;
    cnt_drop_d  = cnt_drop_q;
    sl_valid    = 1'b0;
    sl_data     = axi_rx_tdata;
    sl_keep     = axi_rx_tkeep;
    sl_last     = axi_rx_tlast;
    sl_user     = axi_rx_tuser;

    // live_q holds ready low until the first edge after reset release
    axi_rx_tready = (state_q == DROP) ? 1'b1 : (live_q && sl_ready && state_q != TAG);
    rx_fire       = axi_rx_tvalid && axi_rx_tready;
    first_drop    = (rx_vlan != port_vlan) && !port_trunk;
    first_tagged  = (rx_vlan != port_vlan) && port_trunk;

    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (first_drop) begin
            if (axi_rx_tlast) cnt_drop_d = sat_inc(cnt_drop_q);
            else              state_d    = DROP;
          end else begin
            sl_valid = 1'b1;
            if (axi_rx_tlast) begin
              cnt_untag_d = sat_inc(cnt_untag_q);
            end else begin
              state_d    = HDR;
              word_cnt_d = 2'd1;
              tagged_d   = first_tagged;
              vlan_d     = rx_vlan;
            end
          end
        end
      end
      HDR: begin
        sl_valid = rx_fire;
        if (rx_fire) begin
          // a frame ending inside the MAC header is a runt and never gets a tag
          if (axi_rx_tlast) begin
            state_d     = IDLE;
            cnt_untag_d = sat_inc(cnt_untag_q);
          end else if (word_cnt_q == 2'd2) begin
            state_d = tagged_q ? TAG : BODY;
          end else begin
            word_cnt_d = word_cnt_q + 2'd1;
          end
        end
      end
      TAG: begin
        sl_valid = 1'b1;
        sl_data  = {ETHERTYPE_DOT1Q, 3'b000, 1'b0, vlan_q};
        sl_keep  = 4'hF;
        sl_last  = 1'b0;
        sl_user  = 1'b0;
        if (sl_ready) state_d = BODY;
      end
      BODY: begin
        sl_valid = rx_fire;
        if (rx_fire && axi_rx_tlast) begin
          state_d = IDLE;
          if (tagged_q) cnt_tag_d   = sat_inc(cnt_tag_q);
          else          cnt_untag_d = sat_inc(cnt_untag_q);
        end
      end
      DROP: begin
        if (rx_fire && axi_rx_tlast) begin
          state_d    = IDLE;
          cnt_drop_d = sat_inc(cnt_drop_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      tagged_q    <= 1'b0;
      vlan_q      <= '0;
      live_q      <= 1'b0;
      cnt_tag_q   <= '0;
      cnt_untag_q <= '0;
      cnt_drop_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      tagged_q    <= tagged_d;
      vlan_q      <= vlan_d;
      live_q      <= 1'b1;
      cnt_tag_q   <= cnt_tag_d;
      cnt_untag_q <= cnt_untag_d;
      cnt_drop_q  <= cnt_drop_d;
    end
  end

  axis_register_slice #(
    .DATA_W(32),
    .USER_W(1)
  ) u_out_slice (
    .clk     (aclk),
    .rst_n   (areset_n),
    .s_valid (sl_valid),
    .s_ready (sl_ready),
    .s_data  (sl_data),
    .s_keep  (sl_keep),
    .s_last  (sl_last),
    .s_user  (sl_user),
    .m_valid (axi_tx_tvalid),
    .m_ready (axi_tx_tready),
    .m_data  (axi_tx_tdata),
    .m_keep  (axi_tx_tkeep),
    .m_last  (axi_tx_tlast),
    .m_user  (axi_tx_tuser)
  );

  assign cnt_tagged   = cnt_tag_q;
  assign cnt_untagged = cnt_untag_q;
  assign cnt_dropped  = cnt_drop_q;

endmodule

// File: tb/tb_line_card_egress_tagger.sv
// Bench for line_card_egress_tagger: byte-level reference model of tag insertion,
// directed and randomized frames, output stall stability, counters and reset.
module tb_line_card_egress_tagger;

  typedef logic [37:0] beat_t;   // {data, keep, last, user}

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        axi_rx_tvalid = 1'b0;
  logic        axi_rx_tready;
  logic [31:0] axi_rx_tdata = '0;
  logic [3:0]  axi_rx_tkeep = '0;
  logic        axi_rx_tlast = 1'b0;
  logic        axi_rx_tuser = 1'b0;
  logic [11:0] rx_vlan = '0;
  logic        axi_tx_tvalid;
  logic        axi_tx_tready = 1'b1;
  logic [31:0] axi_tx_tdata;
  logic [3:0]  axi_tx_tkeep;
  logic        axi_tx_tlast;
  logic        axi_tx_tuser;
  logic [11:0] port_vlan = '0;
  logic        port_trunk = 1'b0;
  logic [31:0] cnt_tagged, cnt_untagged, cnt_dropped;

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       out_q[$];
  beat_t       exp_q[$];
  beat_t       last_out[$];
  byte unsigned frm[$];
  logic [31:0] exp_tag = '0, exp_untag = '0, exp_drop = '0;
  bit          rnd_ready = 1'b0;
  int          tvalid_cycles = 0;
  bit          stall_prev = 1'b0;
  beat_t       stall_beat;

  line_card_egress_tagger dut (
    .aclk          (aclk),
    .areset_n      (areset_n),
    .axi_rx_tvalid (axi_rx_tvalid),
    .axi_rx_tready (axi_rx_tready),
    .axi_rx_tdata  (axi_rx_tdata),
    .axi_rx_tkeep  (axi_rx_tkeep),
    .axi_rx_tlast  (axi_rx_tlast),
    .axi_rx_tuser  (axi_rx_tuser),
    .rx_vlan       (rx_vlan),
    .axi_tx_tvalid (axi_tx_tvalid),
    .axi_tx_tready (axi_tx_tready),
    .axi_tx_tdata  (axi_tx_tdata),
    .axi_tx_tkeep  (axi_tx_tkeep),
    .axi_tx_tlast  (axi_tx_tlast),
    .axi_tx_tuser  (axi_tx_tuser),
    .port_vlan     (port_vlan),
    .port_trunk    (port_trunk),
    .cnt_tagged    (cnt_tagged),
    .cnt_untagged  (cnt_untagged),
    .cnt_dropped   (cnt_dropped)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    axi_tx_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: collects accepted beats and checks stability during stalls.
  always @(negedge aclk) begin
    if (areset_n) begin
      if (stall_prev) begin
        n_tests++;
        assert ({axi_tx_tvalid, axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast, axi_tx_tuser} === {1'b1, stall_beat})
        else begin
          n_fail++;
          $error("FAIL stall_hold observed=%h expected=%h",
                 {axi_tx_tvalid, axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast, axi_tx_tuser}, {1'b1, stall_beat});
        end
      end
      if (axi_tx_tvalid) tvalid_cycles++;
      if (axi_tx_tvalid && axi_tx_tready)
        out_q.push_back({axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast, axi_tx_tuser});
      stall_prev = axi_tx_tvalid && !axi_tx_tready;
      stall_beat = {axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast, axi_tx_tuser};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic make_frame(input int nbytes);
    frm.delete();
    for (int i = 0; i < nbytes; i++) frm.push_back(8'($urandom));
  endtask

  function automatic beat_t pack_beat(input byte unsigned q[$], input int w, input logic user);
    logic [31:0] d;
    logic [3:0]  kp;
    int          n;
    logic        last;
    d = '0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (w * 4 + k < q.size()) begin
        d[31 - 8 * k -: 8] = q[w * 4 + k];
        n++;
      end
    end
    kp   = 4'b1111 << (4 - n);
    last = (w * 4 + 4 >= q.size());
    return {d, kp, last, last ? user : 1'b0};
  endfunction

  // Reference: classify, insert 4 tag bytes after the 12 MAC bytes, repack into beats.
  task automatic build_expected(input logic [11:0] vid, input logic [11:0] pv,
                                input logic trunk, input logic user);
    byte unsigned e[$];
    if (vid != pv && !trunk) begin
      if (exp_drop != 32'hFFFF_FFFF) exp_drop++;
      return;
    end
    e = frm;
    if (vid != pv && e.size() > 12) begin
      e.insert(12, 8'h81);
      e.insert(13, 8'h00);
      e.insert(14, {4'h0, vid[11:8]});
      e.insert(15, vid[7:0]);
      exp_tag++;
    end else begin
      exp_untag++;
    end
    for (int w = 0; w * 4 < e.size(); w++) exp_q.push_back(pack_beat(e, w, user));
  endtask

  task automatic drive_frame(input logic [11:0] vid, input logic [11:0] pv, input logic trunk,
                             input logic user, input int abort_at, output int waits);
    int    nw;
    int    k;
    bit    timed_out;
    beat_t b;
    nw = (frm.size() + 3) / 4;
    waits = 0;
    timed_out = 1'b0;
    for (int w = 0; w < nw; w++) begin
      b = pack_beat(frm, w, user);
      {axi_rx_tdata, axi_rx_tkeep, axi_rx_tlast, axi_rx_tuser} = b;
      axi_rx_tvalid = 1'b1;
      if (w == 0) begin
        rx_vlan = vid;
        port_vlan = pv;
        port_trunk = trunk;
      end
      k = 0;
      forever begin
        @(negedge aclk);
        if (axi_rx_tready) break;
        waits++;
        k++;
        if (k >= 500) break;
      end
      if (k >= 500) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge aclk);
      #1;
      if (w == 0) begin
        rx_vlan = 12'($urandom);
        port_vlan = 12'($urandom);
        port_trunk = 1'($urandom);
      end
      if (w == abort_at) break;
    end
    axi_rx_tvalid = 1'b0;
    axi_rx_tlast = 1'b0;
    check("rx_accept_timeout", 64'(timed_out), 64'd0);
  endtask

  task automatic drain_and_compare(input string tag);
    int k;
    int n;
    k = 0;
    while (out_q.size() < exp_q.size() && k < 400) begin
      @(posedge aclk);
      k++;
    end
    repeat (4) @(posedge aclk);
    #1;
    check({tag, "_beats"}, 64'(out_q.size()), 64'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
    last_out = out_q;
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_tagged"}, 64'(cnt_tagged), 64'(exp_tag));
    check({tag, "_cnt_untagged"}, 64'(cnt_untagged), 64'(exp_untag));
    check({tag, "_cnt_dropped"}, 64'(cnt_dropped), 64'(exp_drop));
  endtask

  task automatic run_frame(input string tag, input logic [11:0] vid, input logic [11:0] pv,
                           input logic trunk, input logic user, output int waits);
    build_expected(vid, pv, trunk, user);
    drive_frame(vid, pv, trunk, user, -1, waits);
    drain_and_compare(tag);
    check_counters(tag);
  endtask

  task automatic set_rnd_ready(input bit v);
    rnd_ready = v;
    repeat (2) @(posedge aclk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int total_waits;
    logic [11:0] vid, pv;
    logic trunk, user;

    // Reset state
    #12;
    check("rst_tx_tvalid", 64'(axi_tx_tvalid), 64'd0);
    check("rst_rx_tready", 64'(axi_rx_tready), 64'd0);
    check_counters("rst");
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    check("rel_rx_tready_before_edge", 64'(axi_rx_tready), 64'd0);
    @(posedge aclk);
    #1;
    check("rel_rx_tready_after_edge", 64'(axi_rx_tready), 64'd1);

    // Native VLAN, 64 bytes: unmodified
    make_frame(64);
    run_frame("native64", 12'd69, 12'd69, 1'b0, 1'b0, waits);
    check("native64_len", 64'(last_out.size()), 64'd16);

    // Trunk, foreign VLAN: tag after the MAC addresses
    make_frame(64);
    run_frame("tag64", 12'd10, 12'd69, 1'b1, 1'b0, waits);
    check("tag64_len", 64'(last_out.size()), 64'd17);
    if (last_out.size() > 3) check("tag64_word3", 64'(last_out[3][37:6]), 64'h8100000A);

    // Access port, foreign VLAN: dropped without stalling the input
    tvalid_cycles = 0;
    make_frame(64);
    run_frame("drop64", 12'd10, 12'd69, 1'b0, 1'b1, waits);
    check("drop64_rx_waits", 64'(waits), 64'd0);
    check("drop64_tx_tvalid_cycles", 64'(tvalid_cycles), 64'd0);

    // Tagged frame under random output backpressure
    set_rnd_ready(1'b1);
    make_frame(int'($urandom_range(40, 100)));
    run_frame("tag_bp", 12'h5A3, 12'd69, 1'b1, 1'b1, waits);
    set_rnd_ready(1'b0);

    // 8-byte runt on a trunk with foreign VLAN: no tag, counted untagged
    make_frame(8);
    run_frame("runt8", 12'd10, 12'd69, 1'b1, 1'b0, waits);
    check("runt8_len", 64'(last_out.size()), 64'd2);

    // Randomized frames
    for (int i = 0; i < 30; i++) begin
      pv = 12'($urandom);
      vid = ($urandom_range(0, 2) == 0) ? pv : 12'($urandom);
      trunk = 1'($urandom);
      user = 1'($urandom);
      set_rnd_ready(1'($urandom));
      make_frame(int'($urandom_range(1, 90)));
      run_frame($sformatf("rnd%0d", i), vid, pv, trunk, user, waits);
    end
    set_rnd_ready(1'b0);

    // Back-to-back tagged frames: only the tag cycle stalls the input
    total_waits = 0;
    for (int f = 0; f < 3; f++) begin
      make_frame(64);
      build_expected(12'h123 + 12'(f), 12'd69, 1'b1, 1'(f));
      drive_frame(12'h123 + 12'(f), 12'd69, 1'b1, 1'(f), -1, waits);
      total_waits += waits;
    end
    drain_and_compare("b2b");
    check_counters("b2b");
    check("b2b_rx_waits", 64'(total_waits), 64'd3);

    // Reset mid-frame, then a clean frame from word 0
    make_frame(64);
    drive_frame(12'd10, 12'd69, 1'b1, 1'b0, 6, waits);
    #2;
    areset_n = 1'b0;
    #3;
    check("midrst_tx_tvalid", 64'(axi_tx_tvalid), 64'd0);
    check("midrst_rx_tready", 64'(axi_rx_tready), 64'd0);
    exp_tag = '0;
    exp_untag = '0;
    exp_drop = '0;
    check_counters("midrst");
    out_q.delete();
    exp_q.delete();
    @(negedge aclk);
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    make_frame(48);
    run_frame("post_rst", 12'd10, 12'd69, 1'b1, 1'b0, waits);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_card_egress_tagger.md
LINE_CARD_EGRESS_TAGGER -- requirements
Module: line_card_egress_tagger

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset: aclk  in  1  clock; areset_n  in  1  async active-low reset.
REQ-002 SHALL have these ports, one per line:
- axi_rx_tvalid  in  1  fabric-side frame beat valid.
- axi_rx_tready  out  1  accept.
- axi_rx_tdata  in  32  beat data, first wire byte in [31:24].
- axi_rx_tkeep  in  4  byte enables, MSB-first; only partial on the tlast beat.
- axi_rx_tlast  in  1  end of frame.
- axi_rx_tuser  in  1  frame error, meaningful on the tlast beat.
- rx_vlan  in  12  internal VLAN of the frame, valid with the first beat.
- axi_tx_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/32/4/1/1  port-side egress stream.
- port_vlan  in  12  native (untagged) VLAN of this port.
- port_trunk  in  1  emit non-native VLANs as 802.1Q-tagged.
- cnt_tagged, cnt_untagged, cnt_dropped  out  32 each  frame counters.
REQ-003 SHALL treat incoming frames as untagged: no 802.1Q header on the fabric side.

Function
REQ-010 SHALL sample rx_vlan, port_vlan and port_trunk on the first accepted beat of each frame; mid-frame changes SHALL NOT affect that frame.
REQ-011 SHALL classify each frame as:
- rx_vlan == port_vlan: UNTAGGED, forwarded unmodified.
- else, if port_trunk=1: TAGGED.
- else: DROP, consumed with no output.
REQ-012 TAGGED: SHALL insert exactly one word {16'h8100, 3'b000 PCP, 1'b0 DEI, rx_vlan} after input word 2, i.e. after the 12 MAC-address bytes.
REQ-013 SHALL use FSM states IDLE, HDR, TAG, BODY, DROP:
- IDLE->HDR on the first beat of an UNTAGGED/TAGGED frame; IDLE->DROP on the first beat of a DROP frame.
- HDR counts words 0..2; after word 2 go to TAG if TAGGED, else BODY.
- TAG emits the tag word with axi_rx_tready=0, then goes to BODY.
- BODY/DROP return to IDLE on an accepted tlast.
REQ-014 Runt handling: tlast accepted in HDR SHALL end the frame as sent, with no tag inserted, and SHALL count as untagged.
REQ-015 Output SHALL be a registered slice: data accepted on cycle N appears on axi_tx on cycle N+1. Latency is 1 cycle, plus 1 for the inserted tag word.
REQ-016 axi_rx_tready SHALL be (!axi_tx_tvalid || axi_tx_tready) && state != TAG. In DROP it SHALL be 1 unconditionally.
REQ-017 axi_tx_tvalid SHALL NOT deassert, and tdata/tkeep/tlast/tuser SHALL NOT change, while tvalid=1 && tready=0.
REQ-018 tkeep, tlast and tuser SHALL pass through unchanged on the last beat. The tag word SHALL have tkeep=4'hF, tlast=0, tuser=0.
REQ-019 Back-to-back frames SHALL sustain one beat per cycle with no idle cycles, except the single TAG cycle.
REQ-020 Counters SHALL increment by 1 on the cycle the frame's tlast is accepted at the input, and SHALL saturate at 32'hFFFFFFFF.
REQ-021 A frame that is simultaneously first and last beat (1-word frame) SHALL be treated as a runt (REQ-014), or dropped if classified DROP.

Reset
REQ-030 On areset_n=0, asynchronously: state=IDLE, axi_tx_tvalid=0, axi_rx_tready=0, all counters=0.
REQ-031 Reset mid-frame SHALL abandon the frame; after release the first accepted beat SHALL be treated as a new frame's first beat.
REQ-032 axi_rx_tready SHALL go to 1 on the first aclk edge after reset release.

Structure
REQ-040 The shared Ethernet package SHALL hold: constant ETHERTYPE_DOT1Q=16'h8100, constant VLAN_ID_WIDTH=12, and an enum for the FSM state.
REQ-041 SHALL have one sub-module, axis_register_slice (32-bit, 1-bit tuser), for the output stage. All other logic lives in this module.

Verification
REQ-050 port_vlan=69, rx_vlan=69, 64-byte frame -> 16 output beats identical to input; cnt_untagged=1.
REQ-051 port_vlan=69, port_trunk=1, rx_vlan=10, 64-byte frame -> 17 beats; beat 3 = 32'h8100000A; cnt_tagged=1.
REQ-052 port_trunk=0, rx_vlan=10 -> no axi_tx_tvalid; input never stalls; cnt_dropped=1.
REQ-053 TAGGED frame with axi_tx_tready toggling 50% at random -> output beats byte-identical to the expected tagged frame, and data stable throughout each stall.
REQ-054 8-byte runt with rx_vlan=10, trunk=1 -> 2 beats unmodified; cnt_untagged=1. Then areset_n pulsed mid-frame -> next frame processed correctly from word 0.
